// File: rtl/fifo_rr_merge.sv
// Round-robin merge of nsrc FIFO2-style sources into one destination, with optional burst locking.
// Zero latency, one word per cycle; DST_FULL_N low stalls the transfer without touching grant state.
module fifo_rr_merge #(
    parameter int width = 8,
    parameter int nsrc  = 4,
    parameter int idw   = 2,
    parameter int burst = 1
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    CLR,
    input  logic                    ENABLE,
    input  logic [nsrc-1:0]         SRC_EMPTY_N,
    input  logic [nsrc*width-1:0]   SRC_D_OUT,
    output logic [nsrc-1:0]         SRC_DEQ,
    input  logic                    DST_FULL_N,
    output logic [width-1:0]        DST_D_IN,
    output logic                    DST_ENQ,
    output logic [idw-1:0]          LAST_GRANT
);

    localparam logic [7:0]     BURST_MAX = 8'(burst);
    localparam logic [idw-1:0] LAST_IDX  = idw'(nsrc - 1);

    logic [idw-1:0] ptr_q, ptr_d;
    logic [7:0]     cnt_q, cnt_d;
    logic           lock;
    logic           valid;
    logic           xfer;
    logic [idw-1:0] cand;
    int             scan;

    // Scan starts just after the last-served source, so ptr itself is tried last.
    always_comb begin
        lock  = (cnt_q != 8'd0) && (cnt_q < BURST_MAX) && SRC_EMPTY_N[ptr_q];
        cand  = ptr_q;
        valid = lock;
        scan  = 0;
        if (!lock) begin
            for (int k = 1; k <= nsrc; k++) begin
                scan = int'(ptr_q) + k;
                if (scan >= nsrc) scan = scan - nsrc;
                if (!valid && SRC_EMPTY_N[idw'(scan)]) begin
                    valid = 1'b1;
                    cand  = idw'(scan);
                end
            end
        end
    end

    assign xfer       = !RST && ENABLE && DST_FULL_N && valid;
    assign DST_ENQ    = xfer;
    assign LAST_GRANT = ptr_q;

    always_comb begin
        SRC_DEQ  = '0;
        DST_D_IN = '0;
        if (xfer) begin
            SRC_DEQ[cand] = 1'b1;
            DST_D_IN      = SRC_D_OUT[int'(cand)*width +: width];
        end
    end

    // CLR clears the scheduler even when the same cycle carries a transfer.
    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (RST || CLR) begin
            ptr_d = LAST_IDX;
            cnt_d = 8'd0;
        end else if (xfer) begin
            if (cand == ptr_q && cnt_q != 8'd0) begin
                if (cnt_q < BURST_MAX) cnt_d = cnt_q + 8'd1;
            end else begin
                cnt_d = 8'd1;
                ptr_d = cand;
            end
        end
    end

    always_ff @(posedge CLK) begin
        ptr_q <= ptr_d;
        cnt_q <= cnt_d;
    end

    always @(posedge CLK) begin
        if (!RST) begin
            for (int i = 0; i < nsrc; i++) begin
                assert (!(SRC_DEQ[i] && !SRC_EMPTY_N[i]))
                    else $warning("%m: SRC_DEQ[%0d] asserted on an empty source", i);
            end
            assert (!(DST_ENQ && !DST_FULL_N))
                else $warning("%m: DST_ENQ asserted while destination full");
            assert ($onehot0(SRC_DEQ))
                else $warning("%m: SRC_DEQ not one-hot: %b", SRC_DEQ);
        end
    end

endmodule

// File: doc/fifo_rr_merge.md
Name: fifo_rr_merge

Overview:
- Round-robin scheduler that merges `nsrc` FIFO2-style source queues into one destination FIFO.
- Drains sources through their `EMPTY_N`/`D_OUT`/`DEQ` interfaces and enqueues into the destination through `FULL_N`/`D_IN`/`ENQ`.
- Zero-latency, one word per cycle.
- Optional burst locking lets one source hold the destination for up to `burst` consecutive words.

Parameters:
- width, 8, data word width.
- nsrc, 4, number of source queues (2..16).
- idw, 2, grant index width; 2**idw >= nsrc is required.
- burst, 1, maximum consecutive transfers granted to one source (1..255); 1 gives pure round-robin.

Ports:
- CLK  input  1  clock; all state updates on posedge.
- RST  input  1  reset, synchronous, active-high.
- CLR  input  1  synchronous scheduler clear; same state effect as RST, data path unaffected.
- ENABLE  input  1  permits transfers when high.
- SRC_EMPTY_N  input  nsrc  per-source not-empty; bit i belongs to source i.
- SRC_D_OUT  input  nsrc*width  source heads; source i occupies bits [i*width +: width].
- SRC_DEQ  output  nsrc  per-source dequeue strobe; one-hot or zero.
- DST_FULL_N  input  1  destination not-full.
- DST_D_IN  output  width  data presented to the destination.
- DST_ENQ  output  1  destination enqueue strobe.
- LAST_GRANT  output  idw  registered index of the most recently served source.

Behaviour:
- State registers:
  - `ptr` (idw bits): last-served source.
  - `cnt` (8 bits): consecutive transfers to `ptr`.
- RST or CLR for a cycle sets `ptr` = nsrc-1 and `cnt` = 0, so source 0 has top priority next.
- RST high forces `DST_ENQ` = 0 and `SRC_DEQ` = 0 combinationally. CLR does not gate outputs; transfers in a CLR cycle are legal, but state still clears.
- `LAST_GRANT` = `ptr`, so it reads nsrc-1 after reset.
- Selection (combinational, same cycle):
  - `lock` = (cnt != 0) && (cnt < burst) && SRC_EMPTY_N[ptr].
  - If `lock`, the candidate is `ptr`.
  - Otherwise the candidate is the first i with SRC_EMPTY_N[i] set, scanning ptr+1, ptr+2, … modulo nsrc. The scan includes `ptr` last.
  - `valid` = some candidate exists.
- Transfer condition: `xfer` = !RST && ENABLE && DST_FULL_N && valid.
- When `xfer` is high:
  - `SRC_DEQ[cand]` = 1 and `DST_ENQ` = 1.
  - `DST_D_IN` = SRC_D_OUT slice of `cand`.
- When `xfer` is low: `DST_D_IN` = 0, `SRC_DEQ` = 0, `DST_ENQ` = 0.
- Transfer latency is 0 cycles: data moves on the clock edge ending the cycle in which `xfer` is high.
- State update on a transfer:
  - If cand == ptr and cnt != 0: `cnt` = cnt+1, saturating at burst.
  - Otherwise: `cnt` = 1 and `ptr` = cand.
- No transfer: state holds. A stalled destination (`DST_FULL_N` = 0) therefore preserves lock and priority.
- Boundaries:
  - Lock owner going empty releases the lock immediately (same cycle); the scan continues from ptr+1.
  - Once cnt == burst, the owner is last priority on the next transfer. If it is the only non-empty source, it is re-granted and cnt continues saturated.
  - burst = 1: lock never asserts, giving strict round-robin.
  - Indices wrap modulo nsrc, not 2**idw. Unused high index values are never produced.
  - All sources empty: no strobes, state holds.
  - ENABLE low: no strobes, state holds.
- Assertions (simulation only, RST low):
  - Never SRC_DEQ[i] with SRC_EMPTY_N[i] = 0.
  - Never DST_ENQ with DST_FULL_N = 0.
  - SRC_DEQ at most one-hot.
  - Each violation prints a warning containing `%m`.

Test Plan:
- Reset, then all 4 sources non-empty, DST_FULL_N = 1, burst = 1, ENABLE = 1 for 8 cycles → grant order 0,1,2,3,0,1,2,3; DST_D_IN equals each source's head; LAST_GRANT = 3 after cycle 4.
- burst = 3, sources 0 and 2 each hold 5 words → order 0,0,0,2,2,2,0,0,2,2; cnt never exceeds 3.
- burst = 3, source 1 holds 2 words, source 3 holds 4 words → 1,1, lock released on empty, then 3,3,3,3 (sole source re-granted).
- Grant pending on source 2, DST_FULL_N = 0 for 3 cycles → zero strobes, LAST_GRANT unchanged; DST_FULL_N rising → source 2 transfers that cycle.
- Mid-burst (cnt = 2, ptr = 1), assert RST one cycle → strobes 0 during RST; next cycle, with sources 0 and 1 non-empty, source 0 is granted.
- Mid-burst (cnt = 2, ptr = 1), assert CLR one cycle → same post-clear order as RST, but the transfer in the CLR cycle itself completes.
- Random source fill/drain with ENABLE and DST_FULL_N toggling, 10k cycles → no assertion fires; destination stream equals the per-source streams interleaved in scoreboard-predicted order.
